// File: rtl/zx_mem_pager.sv
// Spectrum 48K/128K/+3 memory pager: decodes 7FFD/1FFD writes and maps the addressed
// 16K quadrant to a ROM or RAM page, with contention and screen-mirror flags.
module zx_mem_pager #(
    parameter int unsigned PLUS3_EN = 1
) (
    input  logic        clk_cpu,
    input  logic        nRESET,
    input  logic [1:0]  model,
    input  logic [15:0] A,
    input  logic [7:0]  D,
    input  logic        nIORQ,
    input  logic        nMREQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nM1,
    output logic        cur_rom,
    output logic [1:0]  cur_rom_page,
    output logic [2:0]  cur_ram_page,
    output logic        cur_contended,
    output logic        cur_vram,
    output logic        cur_vram_bank,
    output logic        vram_we,
    output logic        shadow_scr,
    output logic        locked,
    output logic [7:0]  reg_7ffd,
    output logic [7:0]  reg_1ffd,
    output logic        motor,
    output logic        prn_strobe
);

    localparam logic [1:0] MODEL_48K   = 2'd0;
    localparam logic [1:0] MODEL_128K  = 2'd1;
    localparam logic [1:0] MODEL_PLUS3 = 2'd2;

    logic [7:0] r_7ffd;
    logic [7:0] r_1ffd;
    logic       r_io_we_q;
    logic       r_boot;
    logic [1:0] r_model;

    logic       w_io_we;
    logic       w_commit;
    logic       w_sel_7ffd;
    logic       w_sel_1ffd;
    logic [1:0] w_model_boot;
    logic       w_is_48k;
    logic       w_is_plus3;
    logic       w_special;
    logic [1:0] w_quad;
    logic       w_rom;
    logic [1:0] w_rom_page;
    logic [2:0] w_ram_page;
    logic       w_cont;
    logic       w_vram;
    logic       w_unused;

    assign w_unused   = ^A[11:2];
    assign w_io_we    = !nIORQ && nRD && !nWR && nM1;
    assign w_is_48k   = (r_model == MODEL_48K);
    assign w_is_plus3 = (r_model == MODEL_PLUS3);
    assign w_special  = w_is_plus3 && r_1ffd[0];
    assign w_quad     = A[15:14];

    // Only the rising edge of an IO write commits, so long cycles still write once.
    assign w_commit = r_boot && w_io_we && !r_io_we_q && !r_7ffd[5];

    always_comb begin
        w_model_boot = model;
        if (model == 2'd3 || (model == MODEL_PLUS3 && PLUS3_EN == 0)) begin
            w_model_boot = MODEL_128K;
        end
    end

    always_comb begin
        w_sel_7ffd = 1'b0;
        w_sel_1ffd = 1'b0;
        case (r_model)
            MODEL_128K:  w_sel_7ffd = !A[15] && !A[1] && A[0];
            MODEL_PLUS3: begin
                w_sel_7ffd = (A[15:14] == 2'b01) && !A[1];
                w_sel_1ffd = (A[15:12] == 4'b0001) && !A[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_cpu or negedge nRESET) begin
        if (!nRESET) begin
            r_7ffd    <= 8'd0;
            r_1ffd    <= 8'd0;
            r_io_we_q <= 1'b0;
            r_boot    <= 1'b0;
            r_model   <= MODEL_128K;
        end else begin
            r_io_we_q <= w_io_we;
            if (!r_boot) begin
                r_boot  <= 1'b1;
                r_model <= w_model_boot;
            end
            if (w_commit && w_sel_7ffd) r_7ffd <= D;
            if (w_commit && w_sel_1ffd) r_1ffd <= D;
        end
    end

    always_comb begin
        w_rom      = 1'b0;
        w_rom_page = 2'd0;
        w_ram_page = 3'd0;
        if (w_special) begin
            case (r_1ffd[2:1])
                2'b00:   w_ram_page = {1'b0, w_quad};
                2'b01:   w_ram_page = {1'b1, w_quad};
                2'b10:   w_ram_page = (w_quad == 2'd3) ? 3'd3 : {1'b1, w_quad};
                default: w_ram_page = (w_quad == 2'd1) ? 3'd7 :
                                      (w_quad == 2'd3) ? 3'd3 : {1'b1, w_quad};
            endcase
        end else begin
            case (w_quad)
                2'd0: begin
                    w_rom      = 1'b1;
                    w_rom_page = w_is_48k   ? 2'd1 :
                                 w_is_plus3 ? {r_1ffd[2], r_7ffd[4]} : {1'b0, r_7ffd[4]};
                end
                2'd1:    w_ram_page = 3'd5;
                2'd2:    w_ram_page = 3'd2;
                default: w_ram_page = w_is_48k ? 3'd0 : r_7ffd[2:0];
            endcase
        end
    end

    always_comb begin
        w_cont = w_is_48k ? (w_ram_page == 3'd5) : w_is_plus3 ? w_ram_page[2] : w_ram_page[0];
        w_vram = !w_rom && (w_ram_page == 3'd5 || w_ram_page == 3'd7) && !A[13];
    end

    assign cur_rom       = w_rom;
    assign cur_rom_page  = w_rom_page;
    assign cur_ram_page  = w_ram_page;
    assign cur_contended = !w_rom && w_cont;
    assign cur_vram      = w_vram;
    assign cur_vram_bank = w_vram && w_ram_page[1];
    assign vram_we       = !nMREQ && nRD && !nWR && w_vram && !w_rom;
    assign shadow_scr    = r_7ffd[3];
    assign locked        = r_7ffd[5];
    assign reg_7ffd      = r_7ffd;
    assign reg_1ffd      = r_1ffd;
    assign motor         = r_1ffd[3];
    assign prn_strobe    = r_1ffd[4];

endmodule
